// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator: hcount/vcount, sync, blanking, frame pulse and frame counter.
// Ports: clk/rst (sync, active-high); hcount/hsync/hblnk, vcount/vsync/vblnk, rgb (always 0),
//        frame_start (1-cycle pulse at wrap to (0,0)), frame_cnt (completed frames, modulo 2^16).
// Latency: fixed; every output is a flop decoded from the next counter values.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] hcount,
   output logic        hsync,
   output logic        hblnk,
   output logic [10:0] vcount,
   output logic        vsync,
   output logic        vblnk,
   output logic [11:0] rgb,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // All raster arithmetic is 11 bits wide, so both totals must fit.
   if ((H_TOTAL > 2047) || (V_TOTAL > 2047) || (H_TOTAL < 1) || (V_TOTAL < 1)) begin : g_geometry_check
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..2047");
   end

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] H_HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] H_HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] V_VS_BEG = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] V_VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic        h_wrap;
   logic        v_wrap;
   logic        f_wrap;
   logic [10:0] next_h;
   logic [10:0] next_v;
   logic        hs_act;
   logic        vs_act;

   always_comb begin
      h_wrap = (hcount == H_LAST);
      v_wrap = (vcount == V_LAST);
      f_wrap = h_wrap && v_wrap;
      next_h = h_wrap ? 11'd0 : hcount + 11'd1;
      next_v = vcount;
      if (h_wrap) begin
         next_v = v_wrap ? 11'd0 : vcount + 11'd1;
      end
      // Decode from next_* so the registered flags line up with the registered counters.
      hs_act = (next_h >= H_HS_BEG) && (next_h < H_HS_END);
      vs_act = (next_v >= V_VS_BEG) && (next_v < V_VS_END);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hcount      <= 11'd0;
         vcount      <= 11'd0;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         rgb         <= 12'h000;
         frame_start <= 1'b0;
         frame_cnt   <= 16'h0000;
      end else begin
         hcount      <= next_h;
         vcount      <= next_v;
         hblnk       <= (next_h >= H_ACT);
         vblnk       <= (next_v >= V_ACT);
         // XNOR with the polarity: active-high passes through, active-low inverts.
         hsync       <= hs_act ~^ SYNC_POL;
         vsync       <= vs_act ~^ SYNC_POL;
         rgb         <= 12'h000;
         frame_start <= f_wrap;
         frame_cnt   <= frame_cnt + {15'd0, f_wrap};
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 800x600 geometry, a small active-low geometry
// driven from a vector table, and a 1x1 raster that exercises the frame counter wrap.
module tb_vga_timing_gen;

   logic clk;
   logic rst_a, rst_b, rst_c;

   logic [10:0] a_h, a_v, b_h, b_v, c_h, c_v;
   logic        a_hs, a_hb, a_vs, a_vb, a_fs;
   logic        b_hs, b_hb, b_vs, b_vb, b_fs;
   logic        c_hs, c_hb, c_vs, c_vb, c_fs;
   logic [11:0] a_rgb, b_rgb, c_rgb;
   logic [15:0] a_fc, b_fc, c_fc;

   int n_checks = 0;
   int n_fail   = 0;

   vga_timing_gen dut_a (
      .clk(clk), .rst(rst_a),
      .hcount(a_h), .hsync(a_hs), .hblnk(a_hb),
      .vcount(a_v), .vsync(a_vs), .vblnk(a_vb),
      .rgb(a_rgb), .frame_start(a_fs), .frame_cnt(a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1'b0)
   ) dut_b (
      .clk(clk), .rst(rst_b),
      .hcount(b_h), .hsync(b_hs), .hblnk(b_hb),
      .vcount(b_v), .vsync(b_vs), .vblnk(b_vb),
      .rgb(b_rgb), .frame_start(b_fs), .frame_cnt(b_fc)
   );

   // 1x1 raster: every edge is a frame wrap.
   vga_timing_gen #(
      .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
      .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
      .SYNC_POL(1'b1)
   ) dut_c (
      .clk(clk), .rst(rst_c),
      .hcount(c_h), .hsync(c_hs), .hblnk(c_hb),
      .vcount(c_v), .vsync(c_vs), .vblnk(c_vb),
      .rgb(c_rgb), .frame_start(c_fs), .frame_cnt(c_fc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int          adv;
      logic        rst;
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        hb;
      logic        vs;
      logic        vb;
      logic        fs;
      logic [15:0] fc;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int hs_cnt;
      int first_h;
      int last_h;
      int n;

      // Small geometry: H_TOTAL 14, V_TOTAL 7, 98 clocks/frame, syncs active-low.
      //              adv rst   h   v  hs hb vs vb fs fc
      tbl[0]  = '{ 3, 1'b1,  0,  0, 1, 0, 1, 0, 0, 0};
      tbl[1]  = '{ 1, 1'b0,  1,  0, 1, 0, 1, 0, 0, 0};
      tbl[2]  = '{ 6, 1'b0,  7,  0, 1, 0, 1, 0, 0, 0};
      tbl[3]  = '{ 1, 1'b0,  8,  0, 1, 1, 1, 0, 0, 0};
      tbl[4]  = '{ 2, 1'b0, 10,  0, 0, 1, 1, 0, 0, 0};
      tbl[5]  = '{ 1, 1'b0, 11,  0, 0, 1, 1, 0, 0, 0};
      tbl[6]  = '{ 1, 1'b0, 12,  0, 1, 1, 1, 0, 0, 0};
      tbl[7]  = '{ 1, 1'b0, 13,  0, 1, 1, 1, 0, 0, 0};
      tbl[8]  = '{ 1, 1'b0,  0,  1, 1, 0, 1, 0, 0, 0};
      tbl[9]  = '{42, 1'b0,  0,  4, 1, 0, 1, 1, 0, 0};
      tbl[10] = '{13, 1'b0, 13,  4, 1, 1, 1, 1, 0, 0};
      tbl[11] = '{ 1, 1'b0,  0,  5, 1, 0, 0, 1, 0, 0};
      tbl[12] = '{13, 1'b0, 13,  5, 1, 1, 0, 1, 0, 0};
      tbl[13] = '{ 1, 1'b0,  0,  6, 1, 0, 1, 1, 0, 0};
      tbl[14] = '{13, 1'b0, 13,  6, 1, 1, 1, 1, 0, 0};
      tbl[15] = '{ 1, 1'b0,  0,  0, 1, 0, 1, 0, 1, 1};
      tbl[16] = '{ 1, 1'b0,  1,  0, 1, 0, 1, 0, 0, 1};
      tbl[17] = '{46, 1'b0,  5,  3, 1, 0, 1, 0, 0, 1};
      tbl[18] = '{ 1, 1'b1,  0,  0, 1, 0, 1, 0, 0, 0};
      tbl[19] = '{ 1, 1'b0,  1,  0, 1, 0, 1, 0, 0, 0};

      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;

      // ---- default geometry: reset state ----
      tick(3);
      check("A rst hcount", 32'(a_h), 0);
      check("A rst vcount", 32'(a_v), 0);
      check("A rst hsync", 32'(a_hs), 0);
      check("A rst vsync", 32'(a_vs), 0);
      check("A rst hblnk", 32'(a_hb), 0);
      check("A rst vblnk", 32'(a_vb), 0);
      check("A rst frame_start", 32'(a_fs), 0);
      check("A rst frame_cnt", 32'(a_fc), 0);
      check("A rst rgb", 32'(a_rgb), 0);

      rst_a = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick(1);
         check($sformatf("A post-rst hcount %0d", i), 32'(a_h), 32'(i));
         check($sformatf("A post-rst vcount %0d", i), 32'(a_v), 0);
         check($sformatf("A post-rst frame_start %0d", i), 32'(a_fs), 0);
      end

      // ---- horizontal blanking edge and line wrap ----
      tick(796);
      check("A h799 hcount", 32'(a_h), 799);
      check("A h799 hblnk", 32'(a_hb), 0);
      tick(1);
      check("A h800 hblnk", 32'(a_hb), 1);
      check("A h800 hsync", 32'(a_hs), 0);
      tick(255);
      check("A h1055 hcount", 32'(a_h), 1055);
      check("A h1055 vcount", 32'(a_v), 0);
      tick(1);
      check("A wrap hcount", 32'(a_h), 0);
      check("A wrap vcount", 32'(a_v), 1);
      check("A wrap hblnk", 32'(a_hb), 0);
      check("A wrap frame_start", 32'(a_fs), 0);

      // ---- hsync window over a full line ----
      hs_cnt  = 0;
      first_h = -1;
      last_h  = -1;
      for (int i = 0; i < 1056; i++) begin
         if (a_hs) begin
            hs_cnt++;
            if (first_h < 0) first_h = int'(a_h);
            last_h = int'(a_h);
         end
         tick(1);
      end
      check("A hsync width", 32'(hs_cnt), 128);
      check("A hsync first", 32'(first_h), 840);
      check("A hsync last", 32'(last_h), 967);
      check("A line2 vcount", 32'(a_v), 2);
      check("A line2 vsync", 32'(a_vs), 0);
      check("A line2 vblnk", 32'(a_vb), 0);

      // ---- mid-line reset ----
      tick(500);
      check("A pre-rst hcount", 32'(a_h), 500);
      rst_a = 1'b1;
      tick(1);
      check("A midrst hcount", 32'(a_h), 0);
      check("A midrst vcount", 32'(a_v), 0);
      check("A midrst hblnk", 32'(a_hb), 0);
      check("A midrst frame_start", 32'(a_fs), 0);
      rst_a = 1'b0;
      tick(1);
      check("A midrst release hcount", 32'(a_h), 1);

      // ---- small geometry, table-driven ----
      for (int i = 0; i < 20; i++) begin
         rst_b = tbl[i].rst;
         tick(tbl[i].adv);
         check($sformatf("B vec%0d hcount", i), 32'(b_h), 32'(tbl[i].h));
         check($sformatf("B vec%0d vcount", i), 32'(b_v), 32'(tbl[i].v));
         check($sformatf("B vec%0d hsync", i), 32'(b_hs), 32'(tbl[i].hs));
         check($sformatf("B vec%0d hblnk", i), 32'(b_hb), 32'(tbl[i].hb));
         check($sformatf("B vec%0d vsync", i), 32'(b_vs), 32'(tbl[i].vs));
         check($sformatf("B vec%0d vblnk", i), 32'(b_vb), 32'(tbl[i].vb));
         check($sformatf("B vec%0d frame_start", i), 32'(b_fs), 32'(tbl[i].fs));
         check($sformatf("B vec%0d frame_cnt", i), 32'(b_fc), 32'(tbl[i].fc));
         check($sformatf("B vec%0d rgb", i), 32'(b_rgb), 0);
      end
      rst_b = 1'b0;

      // ---- small geometry: frame pulse spacing (bounded waits) ----
      n = 0;
      while (!b_fs && n < 200) begin
         tick(1);
         n++;
      end
      check("B first pulse delay", 32'(n), 97);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!b_fs && n < 200);
      check("B pulse period", 32'(n), 98);
      check("B frame_cnt after 2 frames", 32'(b_fc), 2);

      // ---- 1x1 raster: frame counter wraps after 65536 frames ----
      check("C rst frame_cnt", 32'(c_fc), 0);
      check("C rst frame_start", 32'(c_fs), 0);
      rst_c = 1'b0;
      tick(65535);
      check("C frame_cnt ffff", 32'(c_fc), 32'hFFFF);
      check("C frame_start at ffff", 32'(c_fs), 1);
      tick(1);
      check("C frame_cnt wrap", 32'(c_fc), 0);
      check("C frame_start at wrap", 32'(c_fs), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
